// File: rtl/arb_mux_4_1_if.sv
// Handshake bundle for the 4:1 arbitrating mux: four requester channels in, one registered
// channel out. The master modport is the environment side, slave is the arbiter side.
interface arb_mux_4_1_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_last;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       out_sel;
    logic             out_ready;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/arb_mux_4_1.sv
// Round-robin, burst-locked 4:1 arbiter feeding a single registered output stage.
// A requester granted without in_last keeps the channel until its last beat is transferred.
module arb_mux_4_1 #(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    arb_mux_4_1_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e           state_q, state_d;
    logic [1:0]       own_q, own_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [1:0]       out_sel_q, out_sel_d;

    logic             accept_en;
    logic             found;
    logic [1:0]       cand;
    logic [1:0]       idx;
    logic [1:0]       gsel;
    logic [3:0]       in_ready;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    always_comb begin
        accept_en = ~out_valid_q | bus.out_ready;

        // Rotating priority search starting at ptr_q.
        found = 1'b0;
        cand  = ptr_q;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end

        gsel     = own_q;
        in_ready = '0;
        if (!rst && accept_en) begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        gsel           = cand;
                        in_ready[cand] = 1'b1;
                    end
                end
                StLocked: in_ready[own_q] = 1'b1;
                default: ;
            endcase
        end
        xfer = |(in_ready & bus.in_valid);

        // Only the granted lane is selected, so X on other lanes cannot leak.
        unique case (gsel)
            2'd0:    sel_data = bus.in_data0;
            2'd1:    sel_data = bus.in_data1;
            2'd2:    sel_data = bus.in_data2;
            default: sel_data = bus.in_data3;
        endcase
        sel_last = bus.in_last[gsel];

        state_d     = state_q;
        own_d       = own_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = gsel;
            if (sel_last) begin
                state_d = StIdle;
                ptr_d   = gsel + 2'd1;
            end else begin
                state_d = StLocked;
                own_d   = gsel;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            own_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_arb_mux_4_1.sv
// Directed bench for arb_mux_4_1: round-robin order, wrap-around, burst lock with owner
// bubbles, output stall, mid-burst reset and X isolation on non-granted lanes.
module tb_arb_mux_4_1;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    arb_mux_4_1_if #(.WIDTH(WIDTH)) bus ();

    arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        #1;
        chk({tag, ".in_ready"}, {28'd0, bus.in_ready}, {28'd0, exp});
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                           input logic l, input logic [1:0] s);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({tag, ".out_data"}, {28'd0, bus.out_data}, {28'd0, d});
        chk({tag, ".out_last"}, {31'd0, bus.out_last}, {31'd0, l});
        chk({tag, ".out_sel"}, {30'd0, bus.out_sel}, {30'd0, s});
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.in_data0  = 4'h1;
        bus.in_data1  = 4'h2;
        bus.in_data2  = 4'h3;
        bus.in_data3  = 4'h4;
        bus.out_ready = 1'b1;

        // Reset values; nothing accepted while rst is high even with all valid.
        cyc();
        cyc();
        chk_out("reset", 1'b0, 4'h0, 1'b0, 2'd0);
        chk_rdy("reset", 4'b0000);

        // Round robin 0,1,2,3,0 at one beat per cycle.
        rst = 1'b0;
        chk_rdy("rr0", 4'b0001);
        cyc(); chk_out("rr0", 1'b1, 4'h1, 1'b1, 2'd0);
        chk_rdy("rr1", 4'b0010);
        cyc(); chk_out("rr1", 1'b1, 4'h2, 1'b1, 2'd1);
        chk_rdy("rr2", 4'b0100);
        cyc(); chk_out("rr2", 1'b1, 4'h3, 1'b1, 2'd2);
        chk_rdy("rr3", 4'b1000);
        cyc(); chk_out("rr3", 1'b1, 4'h4, 1'b1, 2'd3);
        chk_rdy("rr4", 4'b0001);
        cyc(); chk_out("rr4", 1'b1, 4'h1, 1'b1, 2'd0);

        // Drain: output consumed, no input -> valid drops, payload holds.
        bus.in_valid = 4'b0000;
        chk_rdy("drain", 4'b0000);
        cyc(); chk_out("drain", 1'b0, 4'h1, 1'b1, 2'd0);

        // ptr=1: grant 1, then ptr=2 wraps past 2,3 to 0, then ptr=1 grants 1 again.
        bus.in_valid = 4'b0011;
        chk_rdy("wrap_a", 4'b0010);
        cyc(); chk_out("wrap_a", 1'b1, 4'h2, 1'b1, 2'd1);
        chk_rdy("wrap_b", 4'b0001);
        cyc(); chk_out("wrap_b", 1'b1, 4'h1, 1'b1, 2'd0);
        chk_rdy("wrap_c", 4'b0010);
        cyc(); chk_out("wrap_c", 1'b1, 4'h2, 1'b1, 2'd1);

        // ptr=2: one single-beat grant to 0 moves ptr to 1.
        bus.in_valid = 4'b0001;
        chk_rdy("pre_burst", 4'b0001);
        cyc();

        // Requester 1 burst 5,6,(bubble x2),7 with requester 0 valid throughout.
        bus.in_valid = 4'b0011;
        bus.in_last  = 4'b0000;
        bus.in_data0 = 4'h9;
        bus.in_data1 = 4'h5;
        chk_rdy("burst5", 4'b0010);
        cyc(); chk_out("burst5", 1'b1, 4'h5, 1'b0, 2'd1);
        bus.in_data1 = 4'h6;
        chk_rdy("burst6", 4'b0010);
        cyc(); chk_out("burst6", 1'b1, 4'h6, 1'b0, 2'd1);
        bus.in_valid = 4'b0001;
        chk_rdy("bubble1", 4'b0010);
        cyc(); chk_out("bubble1", 1'b0, 4'h6, 1'b0, 2'd1);
        chk_rdy("bubble2", 4'b0010);
        cyc(); chk_out("bubble2", 1'b0, 4'h6, 1'b0, 2'd1);
        bus.in_valid = 4'b0011;
        bus.in_last  = 4'b0010;
        bus.in_data1 = 4'h7;
        chk_rdy("burst7", 4'b0010);
        cyc(); chk_out("burst7", 1'b1, 4'h7, 1'b1, 2'd1);
        bus.in_valid = 4'b0001;
        bus.in_last  = 4'b0001;
        chk_rdy("after_burst", 4'b0001);
        cyc(); chk_out("after_burst", 1'b1, 4'h9, 1'b1, 2'd0);

        // Stall with 'hA held: no input accepted, payload frozen; release -> next beat.
        bus.in_data0 = 4'hA;
        chk_rdy("load_a", 4'b0001);
        cyc(); chk_out("load_a", 1'b1, 4'hA, 1'b1, 2'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        bus.in_last   = 4'b0010;
        bus.in_data1  = 4'hB;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("stall", 4'b0000);
            cyc(); chk_out("stall", 1'b1, 4'hA, 1'b1, 2'd0);
        end
        bus.out_ready = 1'b1;
        chk_rdy("release", 4'b0010);
        cyc(); chk_out("release", 1'b1, 4'hB, 1'b1, 2'd1);

        // ptr=2: requester 3 opens a burst, then reset drops owner and held beat.
        bus.in_valid = 4'b1000;
        bus.in_last  = 4'b0000;
        bus.in_data3 = 4'hC;
        chk_rdy("burst3", 4'b1000);
        cyc(); chk_out("burst3", 1'b1, 4'hC, 1'b0, 2'd3);
        rst = 1'b1;
        chk_rdy("mid_rst", 4'b0000);
        cyc(); chk_out("mid_rst", 1'b0, 4'h0, 1'b0, 2'd0);
        rst          = 1'b0;
        bus.in_valid = 4'b1001;
        bus.in_last  = 4'b1001;
        bus.in_data0 = 4'hD;
        chk_rdy("post_rst", 4'b0001);
        cyc(); chk_out("post_rst", 1'b1, 4'hD, 1'b1, 2'd0);

        // ptr=1: grant to 2 with X on every other lane.
        bus.in_valid = 4'b0100;
        bus.in_last  = 4'b0100;
        bus.in_data0 = 'x;
        bus.in_data1 = 'x;
        bus.in_data3 = 'x;
        bus.in_data2 = 4'h3;
        chk_rdy("xiso", 4'b0100);
        cyc(); chk_out("xiso", 1'b1, 4'h3, 1'b1, 2'd2);
        bus.in_valid = 4'b0000;
        chk_rdy("xiso_idle", 4'b0000);
        cyc(); chk_out("xiso_idle", 1'b0, 4'h3, 1'b1, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_mux_4_1.md
ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each requester and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  4  bit i = requester i offers a beat.
REQ-005 in_data0..in_data3  input  WIDTH each  beat payload of requesters 0..3.
REQ-006 in_last  input  4  bit i = beat from requester i ends its burst.
REQ-007 in_ready  output  4  bit i = beat from requester i is accepted this cycle.
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  WIDTH  registered payload.
REQ-010 out_last  output  1  registered last flag.
REQ-011 out_sel  output  2  index of the requester that supplied the registered beat.
REQ-012 out_ready  input  1  downstream accepts the output beat.

Function
REQ-013 Block shall share one registered output channel among 4 requesters with round-robin, burst-locked arbitration.
REQ-014 Transfer on input i shall occur when in_valid[i] & in_ready[i]; output transfer when out_valid & out_ready.
REQ-015 accept_en = ~out_valid | out_ready; in_ready shall be all-zero when accept_en = 0 or rst = 1.
REQ-016 At most one in_ready bit shall be 1 in any cycle.
REQ-017 State machine: IDLE (no owner) and LOCKED (owner register own[1:0]); plus priority pointer ptr[1:0].
REQ-018 IDLE: if accept_en, grant g = first i with in_valid[i] searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); in_ready[g] = 1 same cycle (combinational from in_valid); none valid -> no grant, state unchanged.
REQ-019 IDLE grant with in_last[g] = 1 -> stay IDLE, ptr <= g+1 (mod 4); with in_last[g] = 0 -> LOCKED, own <= g.
REQ-020 LOCKED: in_ready[own] = accept_en; all other in_ready = 0 regardless of their valid.
REQ-021 LOCKED transfer with in_last[own] = 1 -> IDLE, ptr <= own+1 (mod 4); without last -> stay LOCKED.
REQ-022 LOCKED with in_valid[own] = 0 -> no transfer, stay LOCKED (owner bubble does not release lock).
REQ-023 On any input transfer: out_valid <= 1, out_data <= in_data of granted requester, out_last <= in_last[g], out_sel <= g; latency input transfer -> out_valid = 1 cycle.
REQ-024 Output transfer with no input transfer same cycle -> out_valid <= 0; out_data/out_last/out_sel hold.
REQ-025 Simultaneous output and input transfer -> register reloads with new beat, out_valid stays 1 (full throughput, one beat per cycle).
REQ-026 out_valid = 1 and out_ready = 0 -> all output registers hold; no input accepted.
REQ-027 Payload of non-granted requesters shall never reach out_data; X on non-granted in_data shall not propagate.

Reset
REQ-028 On clk edge with rst = 1: out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, state = IDLE, ptr = 0.
REQ-029 Reset mid-burst or with a beat held shall discard owner and held beat; first post-reset grant follows ptr = 0.
REQ-030 in_ready = 0 during any cycle rst = 1.

Verification
REQ-031 After reset, in_valid = 4'b1111, all in_last = 1, out_ready = 1 -> out_sel sequence 0,1,2,3,0 on successive beats, one beat per cycle.
REQ-032 ptr = 2 (after grant to 1), in_valid = 4'b0011 -> grant 0 (wrap-around skip of 2,3), then ptr = 1.
REQ-033 Requester 1 burst data 'h5,'h6,'h7 (last on 'h7) with requester 0 valid throughout -> out_data 5,6,7 all out_sel = 1, then requester 0 granted; owner drops valid 2 cycles mid-burst -> requester 0 still blocked.
REQ-034 out_ready = 0 with out_valid = 1, out_data = 'hA -> in_ready = 0, out_data holds 'hA for all stall cycles; release -> next beat appears 1 cycle after.
REQ-035 rst pulsed mid-burst of requester 3 -> next cycle out_valid = 0, state IDLE; in_valid = 4'b1001 -> grant 0.
REQ-036 Non-granted in_data = 'x with grant to requester 2 data 'h3 -> out_data = 'h3, no X on outputs.
